// File: rtl/mem_arbiter_2to1_pkg.sv
// boa_arb_pkg: owner encoding and reset constants shared by the boa bus arbiters
package boa_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} arb_owner_t;
  localparam arb_owner_t ARB_RESET_LAST = OWN_B;
  function automatic logic is_req(input logic re, input logic [3:0] we);
    return re | (|we);
  endfunction
endpackage

// File: rtl/mem_arbiter_2to1_if.sv
// boa_mem_bus: boa memory bus; CPU is the requesting side, MEM the serving side
interface boa_mem_bus;
  logic        re;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  modport MEM (input re, we, addr, wdata, output rdata, ready);
  modport CPU (output re, we, addr, wdata, input rdata, ready);
endinterface

// File: rtl/mem_arbiter_2to1_pick2.sv
// arb_pick2: combinational two-way grant selection with lock hold and round-robin tie-break
module arb_pick2
  import boa_arb_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  arb_owner_t last,
  input  logic       lock,
  input  arb_owner_t cur,
  output arb_owner_t grant
);
  // a locked grant sticks; on a tie the master that did not go last wins
  always_comb
    grant = lock ? cur :
            (req_a & req_b) ? ((last == OWN_A) ? OWN_B : OWN_A) :
            req_a ? OWN_A :
            req_b ? OWN_B : OWN_NONE;
endmodule

// File: rtl/mem_arbiter_2to1.sv
// mem_arbiter_2to1: two boa masters onto one slave; MEM_ARBITER_RR_EN selects round-robin over fixed A priority
module mem_arbiter_2to1
  import boa_arb_pkg::*;
(
  input logic     clk,
  input logic     rst,
  boa_mem_bus.MEM a,
  boa_mem_bus.MEM b,
  boa_mem_bus.CPU s
);
  arb_owner_t grant, cur, owner, last;
  logic lock, req_a, req_b, gnt_a, gnt_b, done;
  assign req_a = is_req(a.re, a.we);
  assign req_b = is_req(b.re, b.we);
  arb_pick2 u_pick (
    .req_a (req_a),
    .req_b (req_b),
    .last  (last),
    .lock  (lock),
    .cur   (cur),
    .grant (grant)
  );
  assign gnt_a = ~rst & (grant == OWN_A);
  assign gnt_b = ~rst & (grant == OWN_B);
  assign done  = (gnt_a | gnt_b) & s.ready;
  assign s.re    = gnt_a ? a.re    : gnt_b ? b.re    : 1'b0;
  assign s.we    = gnt_a ? a.we    : gnt_b ? b.we    : 4'b0;
  assign s.addr  = gnt_a ? a.addr  : gnt_b ? b.addr  : 32'b0;
  assign s.wdata = gnt_a ? a.wdata : gnt_b ? b.wdata : 32'b0;
  assign a.ready = gnt_a & s.ready;
  assign b.ready = gnt_b & s.ready;
  assign a.rdata = (owner == OWN_A) ? s.rdata : 32'b0;
  assign b.rdata = (owner == OWN_B) ? s.rdata : 32'b0;
  // hold the grant across slave stalls and route next-cycle read data to the completing reader
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lock  <= 1'b0;
      cur   <= OWN_NONE;
      owner <= OWN_NONE;
    end else begin
      lock  <= (gnt_a | gnt_b) & ~s.ready;
      cur   <= grant;
      owner <= (done & s.re) ? grant : OWN_NONE;
    end
`ifdef MEM_ARBITER_RR_EN
  // remember the last completing master for the round-robin tie-break
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= ARB_RESET_LAST;
    else if (done) last <= grant;
`else
  assign last = ARB_RESET_LAST;
`endif
endmodule
